bb8051_alu_dest_wb: RTL and testbench
=====================================

# bb8051_alu_dest_wb

Result write-back stage of the bb8051 core: the destination end of the ALU datapath that the source selector feeds. It accepts each ALU result with a valid/ready handshake and commits it to the architectural ACC, B and PSW flag registers it owns, or to internal RAM through a request/acknowledge port. It also drives `acc_out`, `b_reg_out` and `psw_out` back to the operand selector and the decoder.

## Interface
- `RAM_ACC_ADDR`, default 8'hE0: direct address that aliases ACC.
- `RAM_B_ADDR`, default 8'hF0: direct address that aliases B.
- `RAM_PSW_ADDR`, default 8'hD0: direct address that aliases PSW.
- `clk` in 1: core clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wb_valid` in 1: ALU result and controls are valid this cycle.
- `wb_ready` out 1: the block can accept a result.
- `dest_sel` in 3: destination code. 0 NO, 1 ACC, 2 B, 3 RAM, 4 ACC_B. Codes 5–7 are treated as NO.
- `ram_addr` in 8: direct address used when `dest_sel`=RAM.
- `alu_res_lo` in 8: result low byte.
- `alu_res_hi` in 8: result high byte. Used only by ACC_B (MUL/DIV).
- `alu_cy`, `alu_ac`, `alu_ov` in 1 each: ALU flag outputs.
- `flag_we` in 3: flag update enables. Bit 2 = CY, bit 1 = AC, bit 0 = OV.
- `ram_wr_req` out 1: RAM write request.
- `ram_wr_addr` out 8: RAM write address.
- `ram_wr_data` out 8: RAM write data.
- `ram_wr_ack` in 1: RAM write accepted.
- `acc_out` out 8: ACC register.
- `b_reg_out` out 8: B register.
- `psw_out` out 8: {CY, AC, F0, RS1, RS0, OV, F1, P}.
- `wb_done` out 1: one-cycle pulse when a result has fully committed.

## Operation
- **Accept.** A result is accepted on a rising edge where `wb_valid` and `wb_ready` are both 1. `wb_ready` = (state == IDLE).
- **State machine.** Two states, IDLE and RAM_WAIT.
  - IDLE → RAM_WAIT: on accept with `dest_sel`=RAM and `ram_addr` not equal to any alias address.
  - RAM_WAIT → IDLE: on an edge where `ram_wr_ack`=1.
  - Every other accept stays in IDLE.
- **Destinations (IDLE accept):**
  - ACC: ACC ← `alu_res_lo`.
  - B: B ← `alu_res_lo`.
  - ACC_B: ACC ← `alu_res_lo` and B ← `alu_res_hi` on the same edge.
  - NO: no register or RAM write; flags still apply.
  - RAM to an alias address: writes ACC, B or PSW[7:1] directly. No RAM request is issued.
  - RAM to any other address: latch address and data, enter RAM_WAIT.
- **Flags.** On accept, PSW.CY/AC/OV ← `alu_cy`/`alu_ac`/`alu_ov` for each set `flag_we` bit. If the same accept is a direct PSW write, the direct write wins for all bits.
- **Parity.** P (`psw_out[0]`) is combinational: XOR of `acc_out`. It is never stored, and writes to PSW bit 0 are ignored.
- **RAM handshake.** In RAM_WAIT, `ram_wr_req`=1 and the latched address/data are held stable until the ack edge.
  - `ram_wr_ack` seen while in IDLE is ignored.
  - There is no timeout; the block stalls indefinitely.
- **wb_done.** Registered. It pulses the cycle after:
  - an IDLE accept that did not enter RAM_WAIT, or
  - the ack edge in RAM_WAIT.
- **Reset.** Reset asserted mid-RAM_WAIT returns the block to IDLE and drops `ram_wr_req` immediately (asynchronously). The pending write is lost.

## Timing
- Reset values:
  - ACC = 00, B = 00, PSW[7:1] = 0, so `psw_out` = 00.
  - `ram_wr_req` = 0, `ram_wr_addr` = 00, `ram_wr_data` = 00.
  - `wb_done` = 0, `wb_ready` = 1, state IDLE.
- Register and flag writes are visible on `acc_out`, `b_reg_out` and `psw_out` in the cycle after the accept edge (1-cycle latency).
- RAM path:
  - accept at edge N;
  - `ram_wr_req` high from cycle N+1;
  - ack sampled at edge M (M ≥ N+1);
  - `ram_wr_req` low and `wb_ready` high from M+1;
  - `wb_done` high for cycle M+1 only.
  - Minimum occupancy is 2 cycles.
- Back-to-back: register destinations sustain one accept per cycle with no bubble.

## Test plan
- **Reset values.** Release `rst` → all outputs hold the reset values above and `wb_ready`=1.
- **ACC write with flags.** Accept ACC, `alu_res_lo`=8'h96, `alu_cy`=1, `flag_we`=3'b100 → next cycle `acc_out`=96, `psw_out`=8'h80 (P=0), `wb_done`=1 for one cycle.
- **ACC_B write.** Accept ACC_B with lo=8'h07, hi=8'h01, `alu_ov`=1, `flag_we`=3'b001 → `acc_out`=07, `b_reg_out`=01, `psw_out`=8'h05.
- **RAM write with ack delay.** Accept RAM to 8'h30 with data 8'h5A; ack held off for 3 cycles → `ram_wr_req` high with addr 30 / data 5A for 3 cycles and `wb_ready`=0 throughout; after ack, `wb_done` pulses and `wb_ready`=1.
- **PSW alias vs. flag write.** Accept RAM to 8'hD0 with data 8'hFF, `flag_we`=3'b111, `alu_cy`=0 → `psw_out[7:1]`=7'h7F, no RAM request issued.
- **Reset mid-operation.** Assert `rst` two cycles into RAM_WAIT → `ram_wr_req` drops immediately; after release, `wb_ready`=1 and `acc_out`=00.

Source files
------------

// File: rtl/bb8051_alu_dest_wb_if.sv
// bb8051 ALU result bus: valid/ready handshake, destination code,
// result bytes and flag enables from the ALU into write-back.
interface bb8051_alu_dest_wb_if;
  logic       wb_valid;
  logic       wb_ready;
  logic [2:0] dest_sel;
  logic [7:0] ram_addr;
  logic [7:0] alu_res_lo;
  logic [7:0] alu_res_hi;
  logic       alu_cy;
  logic       alu_ac;
  logic       alu_ov;
  logic [2:0] flag_we;

  modport master (
    output wb_valid, dest_sel, ram_addr,
    output alu_res_lo, alu_res_hi,
    output alu_cy, alu_ac, alu_ov, flag_we,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, dest_sel, ram_addr,
    input  alu_res_lo, alu_res_hi,
    input  alu_cy, alu_ac, alu_ov, flag_we,
    output wb_ready
  );
endinterface

// File: rtl/bb8051_alu_dest_wb.sv
// bb8051 write-back: commits ALU results to ACC/B/PSW or to RAM.
// Ports: clk, rst (async low), wb bus (slave), RAM req/ack, ACC/B/PSW, wb_done.
module bb8051_alu_dest_wb #(
  parameter logic [7:0] RAM_ACC_ADDR = 8'hE0,
  parameter logic [7:0] RAM_B_ADDR   = 8'hF0,
  parameter logic [7:0] RAM_PSW_ADDR = 8'hD0
) (
  input  logic                      clk,
  input  logic                      rst,
  bb8051_alu_dest_wb_if.slave       wb,
  output logic                      ram_wr_req,
  output logic [7:0]                ram_wr_addr,
  output logic [7:0]                ram_wr_data,
  input  logic                      ram_wr_ack,
  output logic [7:0]                acc_out,
  output logic [7:0]                b_reg_out,
  output logic [7:0]                psw_out,
  output logic                      wb_done
);

  typedef enum logic {
    IDLE,
    RAM_WAIT
  } state_t;

  state_t     state;
  logic [7:0] acc_q;
  logic [7:0] b_q;
  logic [7:1] psw_q;

  logic       accept;
  logic       wr_acc;
  logic       wr_b;
  logic       wr_psw;
  logic       go_ram;
  logic [7:0] b_data;
  logic       hit_acc;
  logic       hit_b;
  logic       hit_psw;

  assign wb.wb_ready = (state == IDLE);
  assign accept      = wb.wb_valid && wb.wb_ready;

  assign hit_acc = (wb.ram_addr == RAM_ACC_ADDR);
  assign hit_b   = (wb.ram_addr == RAM_B_ADDR);
  assign hit_psw = (wb.ram_addr == RAM_PSW_ADDR);

  always_comb begin
    wr_acc = 1'b0;
    wr_b   = 1'b0;
    wr_psw = 1'b0;
    go_ram = 1'b0;
    b_data = wb.alu_res_lo;
    case (wb.dest_sel)
      3'd1: wr_acc = 1'b1;
      3'd2: wr_b   = 1'b1;
      3'd3: begin
        unique case (1'b1)
          hit_acc: wr_acc = 1'b1;
          hit_b:   wr_b   = 1'b1;
          hit_psw: wr_psw = 1'b1;
          default: go_ram = 1'b1;
        endcase
      end
      3'd4: begin
        wr_acc = 1'b1;
        wr_b   = 1'b1;
        b_data = wb.alu_res_hi;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      b_q   <= '0;
      psw_q <= '0;
    end else if (accept) begin
      if (wr_acc) acc_q <= wb.alu_res_lo;
      if (wr_b)   b_q   <= b_data;
      if (wb.flag_we[2]) psw_q[7] <= wb.alu_cy;
      if (wb.flag_we[1]) psw_q[6] <= wb.alu_ac;
      if (wb.flag_we[0]) psw_q[2] <= wb.alu_ov;
      // a direct PSW write lands after the flag updates and wins
      if (wr_psw) psw_q <= wb.alu_res_lo[7:1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ram_wr_req  <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      wb_done     <= 1'b0;
    end else begin
      wb_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (go_ram) begin
              state       <= RAM_WAIT;
              ram_wr_req  <= 1'b1;
              ram_wr_addr <= wb.ram_addr;
              ram_wr_data <= wb.alu_res_lo;
            end else begin
              wb_done <= 1'b1;
            end
          end
        end
        RAM_WAIT: begin
          if (ram_wr_ack) begin
            state      <= IDLE;
            ram_wr_req <= 1'b0;
            wb_done    <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign acc_out   = acc_q;
  assign b_reg_out = b_q;
  // parity is derived from ACC, never stored
  assign psw_out   = {psw_q, ^acc_q};

endmodule

// File: tb/tb_bb8051_alu_dest_wb.sv
// Directed bench for bb8051_alu_dest_wb.
// Each task drives one scenario and checks outputs inline.
module tb_bb8051_alu_dest_wb;
  logic       clk;
  logic       rst;
  logic       ram_wr_req;
  logic [7:0] ram_wr_addr;
  logic [7:0] ram_wr_data;
  logic       ram_wr_ack;
  logic [7:0] acc_out;
  logic [7:0] b_reg_out;
  logic [7:0] psw_out;
  logic       wb_done;

  int checks;
  int failures;

  bb8051_alu_dest_wb_if wb_if ();

  bb8051_alu_dest_wb dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb_if.slave),
    .ram_wr_req  (ram_wr_req),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_wr_ack  (ram_wr_ack),
    .acc_out     (acc_out),
    .b_reg_out   (b_reg_out),
    .psw_out     (psw_out),
    .wb_done     (wb_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    wb_if.wb_valid   = 1'b0;
    wb_if.dest_sel   = 3'd0;
    wb_if.ram_addr   = 8'h00;
    wb_if.alu_res_lo = 8'h00;
    wb_if.alu_res_hi = 8'h00;
    wb_if.alu_cy     = 1'b0;
    wb_if.alu_ac     = 1'b0;
    wb_if.alu_ov     = 1'b0;
    wb_if.flag_we    = 3'b000;
    ram_wr_ack       = 1'b0;
  endtask

  task automatic drive(input logic [2:0] d, input logic [7:0] a,
                       input logic [7:0] lo, input logic [7:0] hi,
                       input logic cy, input logic ac, input logic ov,
                       input logic [2:0] fwe);
    wb_if.wb_valid   = 1'b1;
    wb_if.dest_sel   = d;
    wb_if.ram_addr   = a;
    wb_if.alu_res_lo = lo;
    wb_if.alu_res_hi = hi;
    wb_if.alu_cy     = cy;
    wb_if.alu_ac     = ac;
    wb_if.alu_ov     = ov;
    wb_if.flag_we    = fwe;
  endtask

  task automatic do_reset();
    idle_bus();
    #2 rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic chk8(input string name, input logic [7:0] got,
                      input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    chk8("rst_acc", acc_out, 8'h00);
    chk8("rst_b", b_reg_out, 8'h00);
    chk8("rst_psw", psw_out, 8'h00);
    chk1("rst_req", ram_wr_req, 1'b0);
    chk8("rst_addr", ram_wr_addr, 8'h00);
    chk8("rst_data", ram_wr_data, 8'h00);
    chk1("rst_done", wb_done, 1'b0);
    chk1("rst_ready", wb_if.wb_ready, 1'b1);
  endtask

  task automatic test_acc_flags();
    do_reset();
    drive(3'd1, 8'h00, 8'h96, 8'h00, 1'b1, 1'b0, 1'b0, 3'b100);
    step();
    idle_bus();
    chk8("acc_val", acc_out, 8'h96);
    chk8("acc_psw", psw_out, 8'h80);
    chk1("acc_done", wb_done, 1'b1);
    step();
    chk1("acc_done_off", wb_done, 1'b0);
  endtask

  task automatic test_acc_b();
    do_reset();
    drive(3'd4, 8'h00, 8'h07, 8'h01, 1'b0, 1'b0, 1'b1, 3'b001);
    step();
    idle_bus();
    chk8("accb_acc", acc_out, 8'h07);
    chk8("accb_b", b_reg_out, 8'h01);
    chk8("accb_psw", psw_out, 8'h05);
  endtask

  task automatic test_ram_wait();
    do_reset();
    drive(3'd3, 8'h30, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    idle_bus();
    for (int i = 0; i < 3; i++) begin
      chk1("ram_req", ram_wr_req, 1'b1);
      chk8("ram_addr", ram_wr_addr, 8'h30);
      chk8("ram_data", ram_wr_data, 8'h5A);
      chk1("ram_ready", wb_if.wb_ready, 1'b0);
      chk1("ram_done_early", wb_done, 1'b0);
      step();
    end
    ram_wr_ack = 1'b1;
    step();
    ram_wr_ack = 1'b0;
    chk1("ram_req_off", ram_wr_req, 1'b0);
    chk1("ram_ready_back", wb_if.wb_ready, 1'b1);
    chk1("ram_done", wb_done, 1'b1);
    chk8("ram_acc_keep", acc_out, 8'h00);
    step();
    chk1("ram_done_off", wb_done, 1'b0);
    ram_wr_ack = 1'b1;
    step();
    ram_wr_ack = 1'b0;
    chk1("idle_ack_done", wb_done, 1'b0);
    chk1("idle_ack_req", ram_wr_req, 1'b0);
  endtask

  task automatic test_psw_alias();
    do_reset();
    drive(3'd3, 8'hD0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 3'b111);
    step();
    idle_bus();
    chk8("psw_alias", psw_out, 8'hFE);
    chk1("psw_alias_req", ram_wr_req, 1'b0);
    chk1("psw_alias_done", wb_done, 1'b1);
    chk1("psw_alias_ready", wb_if.wb_ready, 1'b1);
    drive(3'd3, 8'hE0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    drive(3'd3, 8'hF0, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    idle_bus();
    chk8("acc_alias", acc_out, 8'h01);
    chk8("b_alias", b_reg_out, 8'hC3);
    chk8("psw_par", psw_out, 8'hFF);
    chk1("alias_req", ram_wr_req, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(3'd1, 8'h00, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    chk8("b2b_acc1", acc_out, 8'h11);
    chk1("b2b_rdy1", wb_if.wb_ready, 1'b1);
    chk1("b2b_done1", wb_done, 1'b1);
    drive(3'd2, 8'h00, 8'h22, 8'h00, 1'b0, 1'b1, 1'b0, 3'b010);
    step();
    chk8("b2b_b", b_reg_out, 8'h22);
    chk8("b2b_psw_ac", psw_out, 8'h40);
    chk1("b2b_done2", wb_done, 1'b1);
    drive(3'd6, 8'h00, 8'h99, 8'h99, 1'b1, 1'b0, 1'b1, 3'b101);
    step();
    chk8("b2b_no_acc", acc_out, 8'h11);
    chk8("b2b_no_b", b_reg_out, 8'h22);
    chk8("b2b_no_psw", psw_out, 8'hC4);
    chk1("b2b_done3", wb_done, 1'b1);
    drive(3'd1, 8'h00, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 3'b110);
    step();
    idle_bus();
    chk8("b2b_acc2", acc_out, 8'h33);
    chk8("b2b_psw2", psw_out, 8'h04);
    step();
    chk1("b2b_done_off", wb_done, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(3'd1, 8'h00, 8'h5C, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    drive(3'd3, 8'h40, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0, 3'b000);
    step();
    idle_bus();
    step();
    chk1("mid_req_before", ram_wr_req, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("mid_req_drop", ram_wr_req, 1'b0);
    chk1("mid_ready", wb_if.wb_ready, 1'b1);
    step();
    rst = 1'b1;
    step();
    chk1("mid_ready_after", wb_if.wb_ready, 1'b1);
    chk8("mid_acc", acc_out, 8'h00);
    chk1("mid_req_after", ram_wr_req, 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_bus();
    test_reset();
    test_acc_flags();
    test_acc_b();
    test_ram_wait();
    test_psw_alias();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
